// File: rtl/frontend_width_ctrl_pkg.sv
// Shared types and helpers for front-end width reconfiguration.
// The instruction buffer and decode use width_to_mask as well, so the lane
// mapping stays identical on both sides of the width switch.
package frontend_width_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        FLUSH,
        APPLY,
        SETTLE
    } fwc_state_e;

    localparam logic [2:0] MIN_WIDTH = 3'd1;
    localparam logic [2:0] MAX_WIDTH = 3'd4;

    // Lanes fill from slot0 (bit3) downward.
    function automatic logic [3:0] width_to_mask(input logic [2:0] width);
        logic [3:0] mask;
        case (width)
            3'd1:    mask = 4'b1000;
            3'd2:    mask = 4'b1100;
            3'd3:    mask = 4'b1110;
            default: mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/width_settle_timer.sv
// Loadable down-counter with a terminal-count flag.
// Used both for the drain timeout and for the post-widen settle time.
module width_settle_timer
    import frontend_width_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    // Load wins over decrement; decrement holds at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/frontend_width_ctrl.sv
// Front-end width reconfiguration sequencer.
// Stalls fetch, drains (or flushes) the instruction buffer, swaps width and
// lane mask on one edge, then holds the stall while new lanes settle.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | width stable, accepting requests
//   DRAIN  | fetch stalled, buffer dispatching at the old width
//   FLUSH  | one-cycle flush request, buffer empties on this edge
//   APPLY  | width and mask switch on exit
//   SETTLE | widened lanes settling, fetch still stalled
module frontend_width_ctrl
    import frontend_width_ctrl_pkg::*;
#(
    parameter int COUNT_W       = 5,
    parameter int RESET_WIDTH   = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int DRAIN_TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid_i,
    input  logic [2:0]         cfg_width_i,
    output logic               cfg_ready_o,
    output logic               cfg_err_o,
    input  logic               flush_i,
    input  logic [COUNT_W-1:0] buf_count_i,
    output logic               stall_fetch_o,
    output logic               flush_req_o,
    output logic [2:0]         front_end_width_o,
    output logic [3:0]         lane_mask_o,
    output logic               busy_o
);

    localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    fwc_state_e r_state;
    logic [2:0] r_width;
    logic [3:0] r_mask;
    logic [2:0] r_pending;
    logic       r_stall;
    logic       r_flush_req;
    logic       r_err;
    logic       r_busy;
    logic       r_ready;

    logic w_legal;
    logic w_accept;
    logic w_residue;
    logic w_drain_load;
    logic w_drain_dec;
    logic w_drain_done;
    logic w_settle_load;
    logic w_settle_dec;
    logic w_settle_done;

    assign w_legal   = (cfg_width_i >= MIN_WIDTH) && (cfg_width_i <= MAX_WIDTH);
    assign w_accept  = cfg_valid_i && r_ready;
    // Fewer entries than lanes: the leftover group can never dispatch.
    assign w_residue = buf_count_i < COUNT_W'(r_width);

    // Drain timer counts down from DRAIN_TIMEOUT-1; zero means the last allowed DRAIN cycle.
    assign w_drain_load  = w_accept && w_legal && (cfg_width_i != r_width);
    assign w_drain_dec   = (r_state == DRAIN);
    assign w_settle_load = (r_state == APPLY) && (r_pending > r_width);
    assign w_settle_dec  = (r_state == SETTLE);

    width_settle_timer #(.CNT_W(DRAIN_W)) u_drain_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_drain_load),
        .i_load_val (DRAIN_W'(DRAIN_TIMEOUT - 1)),
        .i_dec      (w_drain_dec),
        .o_done     (w_drain_done)
    );

    width_settle_timer #(.CNT_W(SETTLE_W)) u_settle_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_settle_load),
        .i_load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
        .i_dec      (w_settle_dec),
        .o_done     (w_settle_done)
    );

    // Sequencer with registered outputs set on each state transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_width     <= 3'(RESET_WIDTH);
            r_mask      <= width_to_mask(3'(RESET_WIDTH));
            r_pending   <= 3'(RESET_WIDTH);
            r_stall     <= 1'b0;
            r_flush_req <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_flush_req <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_err <= 1'b1;
                        end else if (cfg_width_i != r_width) begin
                            r_pending <= cfg_width_i;
                            r_state   <= DRAIN;
                            r_stall   <= 1'b1;
                            r_busy    <= 1'b1;
                            r_ready   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (flush_i || (buf_count_i == '0)) begin
                        r_state <= APPLY;
                    end else if (w_residue || w_drain_done) begin
                        r_state     <= FLUSH;
                        r_flush_req <= 1'b1;
                    end
                end
                FLUSH: begin
                    r_state <= APPLY;
                end
                APPLY: begin
                    r_width <= r_pending;
                    r_mask  <= width_to_mask(r_pending);
                    if (r_pending > r_width) begin
                        r_state <= SETTLE;
                    end else begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (w_settle_done) begin
                        r_state <= IDLE;
                        r_stall <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_stall <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready_o       = r_ready;
    assign cfg_err_o         = r_err;
    assign stall_fetch_o     = r_stall;
    assign flush_req_o       = r_flush_req;
    assign front_end_width_o = r_width;
    assign lane_mask_o       = r_mask;
    assign busy_o            = r_busy;

endmodule

// File: tb/tb_frontend_width_ctrl.sv
// Directed bench for frontend_width_ctrl with hand-computed expectations.
module tb_frontend_width_ctrl;

    logic       clk;
    logic       reset;
    logic       cfg_valid_i;
    logic [2:0] cfg_width_i;
    logic       cfg_ready_o;
    logic       cfg_err_o;
    logic       flush_i;
    logic [4:0] buf_count_i;
    logic       stall_fetch_o;
    logic       flush_req_o;
    logic [2:0] front_end_width_o;
    logic [3:0] lane_mask_o;
    logic       busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    frontend_width_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .cfg_valid_i       (cfg_valid_i),
        .cfg_width_i       (cfg_width_i),
        .cfg_ready_o       (cfg_ready_o),
        .cfg_err_o         (cfg_err_o),
        .flush_i           (flush_i),
        .buf_count_i       (buf_count_i),
        .stall_fetch_o     (stall_fetch_o),
        .flush_req_o       (flush_req_o),
        .front_end_width_o (front_end_width_o),
        .lane_mask_o       (lane_mask_o),
        .busy_o            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the first cycle after acceptance.
    task automatic req(input logic [2:0] w, input logic [4:0] cnt);
        cfg_valid_i = 1'b1;
        cfg_width_i = w;
        buf_count_i = cnt;
        step();
        cfg_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_o && n < 60) begin
            n++;
            step();
        end
        chk(tag, 32'(busy_o), 0);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        cfg_valid_i = 1'b0;
        cfg_width_i = 3'd0;
        flush_i     = 1'b0;
        buf_count_i = 5'd0;
        step();
        step();
        reset = 1'b0;

        // Reset state held through 5 idle cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_stall", 32'(stall_fetch_o), 0);
        end
        chk("rst_width", 32'(front_end_width_o), 4);
        chk("rst_mask",  32'(lane_mask_o), 32'hF);
        chk("rst_ready", 32'(cfg_ready_o), 1);
        chk("rst_busy",  32'(busy_o), 0);
        chk("rst_err",   32'(cfg_err_o), 0);

        // Narrow 4->2 with empty buffer: DRAIN at 1, APPLY at 2, new width at 3
        req(3'd2, 5'd0);
        chk("n2_c1_stall", 32'(stall_fetch_o), 1);
        chk("n2_c1_busy",  32'(busy_o), 1);
        chk("n2_c1_ready", 32'(cfg_ready_o), 0);
        chk("n2_c1_width", 32'(front_end_width_o), 4);
        step();
        chk("n2_c2_stall", 32'(stall_fetch_o), 1);
        chk("n2_c2_flush", 32'(flush_req_o), 0);
        chk("n2_c2_width", 32'(front_end_width_o), 4);
        step();
        chk("n2_c3_stall", 32'(stall_fetch_o), 0);
        chk("n2_c3_width", 32'(front_end_width_o), 2);
        chk("n2_c3_mask",  32'(lane_mask_o), 32'hC);
        chk("n2_c3_busy",  32'(busy_o), 0);

        // Back to 4
        req(3'd4, 5'd0);
        wait_idle("w4_idle");
        chk("w4_width", 32'(front_end_width_o), 4);

        // 4->3 with residue: 6 then 2 (<4) forces a single flush
        req(3'd3, 5'd6);
        chk("r3_c1_flush", 32'(flush_req_o), 0);
        step();
        buf_count_i = 5'd2;
        chk("r3_c2_busy",  32'(busy_o), 1);
        chk("r3_c2_flush", 32'(flush_req_o), 0);
        step();
        chk("r3_c3_flush", 32'(flush_req_o), 1);
        chk("r3_c3_stall", 32'(stall_fetch_o), 1);
        buf_count_i = 5'd0;
        step();
        chk("r3_c4_flush", 32'(flush_req_o), 0);
        chk("r3_c4_width", 32'(front_end_width_o), 4);
        step();
        chk("r3_c5_width", 32'(front_end_width_o), 3);
        chk("r3_c5_mask",  32'(lane_mask_o), 32'hE);
        chk("r3_c5_stall", 32'(stall_fetch_o), 0);
        chk("r3_c5_busy",  32'(busy_o), 0);

        // 3->1, then 1->4 with 8-cycle settle
        req(3'd1, 5'd0);
        step();
        step();
        chk("n1_width", 32'(front_end_width_o), 1);
        chk("n1_mask",  32'(lane_mask_o), 32'h8);
        req(3'd4, 5'd0);
        step();
        chk("w14_apply_width", 32'(front_end_width_o), 1);
        step();
        chk("w14_width", 32'(front_end_width_o), 4);
        chk("w14_mask",  32'(lane_mask_o), 32'hF);
        n = 0;
        while (stall_fetch_o && n < 50) begin
            n++;
            step();
        end
        chk("w14_settle_len", 32'(n), 8);
        chk("w14_busy", 32'(busy_o), 0);

        // Backend stalled at 10 entries: flush forced after 32 DRAIN cycles
        req(3'd2, 5'd10);
        n = 0;
        while (!flush_req_o && n < 100) begin
            n++;
            step();
        end
        chk("to_drain_len", 32'(n), 32);
        buf_count_i = 5'd0;
        step();
        chk("to_apply_flush", 32'(flush_req_o), 0);
        step();
        chk("to_width", 32'(front_end_width_o), 2);
        chk("to_mask",  32'(lane_mask_o), 32'hC);
        chk("to_stall", 32'(stall_fetch_o), 0);

        // External flush in DRAIN goes straight to APPLY without flush_req
        req(3'd3, 5'd10);
        flush_i = 1'b1;
        step();
        flush_i     = 1'b0;
        buf_count_i = 5'd0;
        chk("xf_flush_req", 32'(flush_req_o), 0);
        chk("xf_busy",      32'(busy_o), 1);
        chk("xf_width_old", 32'(front_end_width_o), 2);
        step();
        chk("xf_width", 32'(front_end_width_o), 3);
        chk("xf_stall", 32'(stall_fetch_o), 1);
        wait_idle("xf_idle");

        // Illegal widths 0 and 6: one-cycle error, no state change
        req(3'd0, 5'd0);
        chk("e0_err",   32'(cfg_err_o), 1);
        chk("e0_busy",  32'(busy_o), 0);
        chk("e0_stall", 32'(stall_fetch_o), 0);
        chk("e0_width", 32'(front_end_width_o), 3);
        step();
        chk("e0_err_drop", 32'(cfg_err_o), 0);
        req(3'd6, 5'd0);
        chk("e6_err",   32'(cfg_err_o), 1);
        chk("e6_busy",  32'(busy_o), 0);
        chk("e6_width", 32'(front_end_width_o), 3);
        step();
        chk("e6_err_drop", 32'(cfg_err_o), 0);

        // Same-width request is a no-op; flush_i in IDLE is ignored
        req(3'd3, 5'd0);
        chk("same_stall", 32'(stall_fetch_o), 0);
        chk("same_busy",  32'(busy_o), 0);
        chk("same_ready", 32'(cfg_ready_o), 1);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        chk("idle_flush_busy", 32'(busy_o), 0);
        chk("idle_flush_req",  32'(flush_req_o), 0);

        // Reset during SETTLE restores reset values on the next edge
        req(3'd1, 5'd0);
        step();
        step();
        req(3'd2, 5'd0);
        step();
        step();
        chk("rs_settle_width", 32'(front_end_width_o), 2);
        chk("rs_settle_stall", 32'(stall_fetch_o), 1);
        reset = 1'b1;
        step();
        chk("rs_width", 32'(front_end_width_o), 4);
        chk("rs_mask",  32'(lane_mask_o), 32'hF);
        chk("rs_stall", 32'(stall_fetch_o), 0);
        chk("rs_busy",  32'(busy_o), 0);
        chk("rs_ready", 32'(cfg_ready_o), 1);
        reset = 1'b0;
        step();
        chk("rs_post_stall", 32'(stall_fetch_o), 0);
        chk("rs_post_width", 32'(front_end_width_o), 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule
